// File: rtl/sat_kbd_pkg.sv
// Shared types, lock codes and the E0-prefixed scancode map for the Saturn keyboard front-end.
package sat_kbd_pkg;

    localparam int unsigned SC_W  = 8;
    localparam int unsigned CNT_W = 24;

    localparam logic [SC_W-1:0] LOCK_CAPS   = 8'h58;
    localparam logic [SC_W-1:0] LOCK_NUM    = 8'h77;
    localparam logic [SC_W-1:0] LOCK_SCROLL = 8'h7E;

    // One queued keyboard event as seen by the packet serializer.
    typedef struct packed {
        logic            make;
        logic [SC_W-1:0] sc;
    } sat_ev_t;

    // Result of a scancode translation.
    typedef struct packed {
        logic            valid;
        logic [SC_W-1:0] sc;
    } sat_map_t;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    // Translate an E0-prefixed set-2 code into a Saturn scancode.
    function automatic sat_map_t sat_map_ext(input logic [SC_W-1:0] code);
        sat_map_t m;
        m.valid = 1'b1;
        m.sc    = code;
        case (code)
            8'h11:               m.sc = 8'h17;
            8'h14:               m.sc = 8'h18;
            8'h5A:               m.sc = 8'h19;
            8'h1F, 8'h27, 8'h2F: m.sc = code;
            8'h4A:               m.sc = 8'h80;
            8'h70:               m.sc = 8'h81;
            8'h7C:               m.sc = 8'h84;
            8'h71:               m.sc = 8'h85;
            8'h6B:               m.sc = 8'h86;
            8'h6C:               m.sc = 8'h87;
            8'h69:               m.sc = 8'h88;
            8'h75:               m.sc = 8'h89;
            8'h72:               m.sc = 8'h8A;
            8'h7D:               m.sc = 8'h8B;
            8'h7A:               m.sc = 8'h8C;
            8'h74:               m.sc = 8'h8D;
            default: begin
                m.valid = 1'b0;
                m.sc    = '0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sat_kbd_fifo.sv
// First-word-fall-through synchronous FIFO; head is forced to zero while empty.
module sat_kbd_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   valid,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             pop_ok;
    logic             push_ok;

    // Qualify requests: pop needs data, push needs a slot (possibly freed by the pop).
    always_comb begin
        pop_ok  = pop && (level_q != '0);
        push_ok = push && ((level_q != LW'(DEPTH)) || pop_ok);
    end

    // Pointer and occupancy registers; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + LW'(1);
            end else if (!push_ok && pop_ok) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign valid = (level_q != '0);
    assign head  = valid ? mem_q[rd_ptr_q] : '0;
    assign level = level_q;

endmodule

// File: rtl/sat_kbd_evq.sv
// Saturn keyboard event front-end: ps2_key decode, lock LEDs, event queue and typematic repeat.
module sat_kbd_evq #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [23:0] DELAY_CYC = 24'd5_000_000,
    parameter logic [23:0] RATE_CYC  = 24'd1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       repeat_en,
    input  logic [10:0]                ps2_key,
    output logic [2:0]                 ps2_led,
    output logic                       ev_valid,
    output logic                       ev_make,
    output logic [7:0]                 ev_sc,
    input  logic                       ev_pop,
    output logic [$clog2(DEPTH+1)-1:0] ev_level,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    import sat_kbd_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH+1);
    // The last slot is kept free for breaks so a held key can always be released.
    localparam logic [LW-1:0] MAKE_LIM = LW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic             toggle_q;
    logic [2:0]       locks_q, locks_d;
    logic             ovf_q, ovf_d;
    rep_state_t       state_q, state_d;
    logic [SC_W-1:0]  rep_sc_q, rep_sc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ps2_evt;
    logic             key_make;
    logic             key_ext;
    logic [SC_W-1:0]  key_code;
    sat_map_t         key_dec;
    logic [2:0]       key_lock_mask;
    logic             key_lock;
    logic             evt_in;
    logic             dup_make;

    logic             pop_eff;
    logic [LW-1:0]    level_ap;
    logic             make_room;
    logic             brk_room;

    logic             push;
    logic             ps2_push;
    sat_ev_t          push_ev;
    sat_ev_t          head;
    logic             fifo_valid;
    logic [LW-1:0]    fifo_level;

    assign ps2_evt  = ps2_key[10] != toggle_q;
    assign key_make = ps2_key[9];
    assign key_ext  = ps2_key[8];
    assign key_code = ps2_key[7:0];

    // Translate the raw code and classify lock keys.
    always_comb begin
        key_dec       = '0;
        key_lock_mask = 3'b000;
        if (key_ext) begin
            key_dec = sat_map_ext(key_code);
        end else begin
            key_dec.valid = !(key_code inside {8'h00, 8'hE0, 8'hE1, 8'hF0});
            key_dec.sc    = key_code;
            case (key_code)
                LOCK_CAPS:   key_lock_mask = 3'b001;
                LOCK_NUM:    key_lock_mask = 3'b010;
                LOCK_SCROLL: key_lock_mask = 3'b100;
                default:     key_lock_mask = 3'b000;
            endcase
        end
        key_lock = |key_lock_mask;
    end

    // Space is judged against the occupancy left after this cycle's pop.
    always_comb begin
        pop_eff   = ev_pop && fifo_valid;
        level_ap  = fifo_level - LW'(pop_eff);
        make_room = level_ap < MAKE_LIM;
        brk_room  = level_ap < FULL_LVL;
        evt_in    = ps2_evt && enable && key_dec.valid;
        dup_make  = evt_in && key_make && repeat_en &&
                    (state_q != REP_IDLE) && (key_dec.sc == rep_sc_q);
    end

    // Push arbitration, lock/overflow updates and typematic next-state.
    always_comb begin
        state_d  = state_q;
        rep_sc_d = rep_sc_q;
        cnt_d    = cnt_q;
        locks_d  = locks_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        ps2_push = 1'b0;
        push_ev  = '0;

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (ps2_evt && key_make) begin
            locks_d = locks_q ^ key_lock_mask;
        end

        if (evt_in && !dup_make) begin
            if (key_make ? make_room : brk_room) begin
                push         = 1'b1;
                ps2_push     = 1'b1;
                push_ev.make = key_make;
                push_ev.sc   = key_dec.sc;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            REP_IDLE: begin
                if (ps2_push && key_make && !key_lock) begin
                    state_d  = REP_DELAY;
                    rep_sc_d = key_dec.sc;
                    cnt_d    = DELAY_CYC - 24'd1;
                end
            end
            REP_DELAY, REP_REPEAT: begin
                if (ps2_push && key_make && !key_lock) begin
                    state_d  = REP_DELAY;
                    rep_sc_d = key_dec.sc;
                    cnt_d    = DELAY_CYC - 24'd1;
                end else if (evt_in && !key_make && (key_dec.sc == rep_sc_q)) begin
                    state_d = REP_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 24'd1;
                end else if (!ps2_evt) begin
                    // Expiry: a full queue skips this repeat silently.
                    state_d = REP_REPEAT;
                    cnt_d   = RATE_CYC - 24'd1;
                    if (repeat_en && enable && make_room) begin
                        push         = 1'b1;
                        push_ev.make = 1'b1;
                        push_ev.sc   = rep_sc_q;
                    end
                end
            end
            default: state_d = REP_IDLE;
        endcase

        if (!enable) begin
            state_d = REP_IDLE;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q <= 1'b0;
            locks_q  <= 3'b000;
            ovf_q    <= 1'b0;
            state_q  <= REP_IDLE;
            rep_sc_q <= '0;
            cnt_q    <= '0;
        end else begin
            toggle_q <= ps2_key[10];
            locks_q  <= locks_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            rep_sc_q <= rep_sc_d;
            cnt_q    <= cnt_d;
        end
    end

    sat_kbd_fifo #(
        .WIDTH ($bits(sat_ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (!enable),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_pop),
        .valid     (fifo_valid),
        .head      (head),
        .level     (fifo_level)
    );

    assign ps2_led  = locks_q;
    assign ovf      = ovf_q;
    assign ev_valid = fifo_valid;
    assign ev_make  = head.make;
    assign ev_sc    = head.sc;
    assign ev_level = fifo_level;

endmodule

// File: tb/tb_sat_kbd_evq.sv
// Bench for sat_kbd_evq: directed vector table, typematic sequences, randomized run vs reference model.
module tb_sat_kbd_evq;

    localparam int unsigned DEPTH = 4;
    localparam int          DLY   = 20;
    localparam int          RATE  = 5;

    logic        clk = 1'b0;
    logic        rst, en, ren, tog, pr, ex, pp, clr;
    logic [7:0]  cd;
    logic [10:0] ps2_key;
    logic [2:0]  led;
    logic        ev_valid, ev_make, ovf;
    logic [7:0]  ev_sc;
    logic [2:0]  ev_level;

    int n_chk  = 0;
    int n_fail = 0;

    assign ps2_key = {tog, pr, ex, cd};

    always #5 clk = ~clk;

    sat_kbd_evq #(
        .DEPTH     (DEPTH),
        .DELAY_CYC (24'd20),
        .RATE_CYC  (24'd5)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .enable    (en),
        .repeat_en (ren),
        .ps2_key   (ps2_key),
        .ps2_led   (led),
        .ev_valid  (ev_valid),
        .ev_make   (ev_make),
        .ev_sc     (ev_sc),
        .ev_pop    (pp),
        .ev_level  (ev_level),
        .ovf       (ovf),
        .ovf_clr   (clr)
    );

    // ---------------- reference model: queue + absolute repeat deadline ----------------
    typedef struct { bit mk; bit [7:0] sc; } mev_t;
    mev_t     mq[$];
    bit       m_ovf, m_tog, m_armed;
    bit [2:0] m_led;
    bit [7:0] m_rep;
    int       m_due, now;

    function automatic void ref_decode(input bit e, input bit [7:0] c, output bit ok, output bit [7:0] sc);
        ok = 1'b1;
        sc = c;
        if (e) begin
            case (c)
                8'h11: sc = 8'h17;  8'h14: sc = 8'h18;  8'h5A: sc = 8'h19;
                8'h1F, 8'h27, 8'h2F: sc = c;
                8'h4A: sc = 8'h80;  8'h70: sc = 8'h81;  8'h7C: sc = 8'h84;
                8'h71: sc = 8'h85;  8'h6B: sc = 8'h86;  8'h6C: sc = 8'h87;
                8'h69: sc = 8'h88;  8'h75: sc = 8'h89;  8'h72: sc = 8'h8A;
                8'h7D: sc = 8'h8B;  8'h7A: sc = 8'h8C;  8'h74: sc = 8'h8D;
                default: ok = 1'b0;
            endcase
        end else if (c == 8'h00 || c == 8'hE0 || c == 8'hE1 || c == 8'hF0) begin
            ok = 1'b0;
        end
    endfunction

    task automatic model_step();
        bit       evt, ok, pushed, lock;
        bit [7:0] sc;
        int       lvl;
        now++;
        if (rst) begin
            mq.delete(); m_ovf = 0; m_led = 0; m_tog = 0; m_armed = 0; m_rep = 0;
            return;
        end
        evt   = (tog != m_tog);
        m_tog = tog;
        ref_decode(ex, cd, ok, sc);
        lock = !ex && (cd == 8'h58 || cd == 8'h77 || cd == 8'h7E);
        if (evt && pr && !ex) begin
            if (cd == 8'h58) m_led[0] = ~m_led[0];
            if (cd == 8'h77) m_led[1] = ~m_led[1];
            if (cd == 8'h7E) m_led[2] = ~m_led[2];
        end
        if (clr) m_ovf = 0;
        if (!en) begin
            mq.delete(); m_armed = 0;
            return;
        end
        if (pp && mq.size() > 0) void'(mq.pop_front());
        lvl = mq.size();
        if (evt && ok && !(m_armed && ren && pr && sc == m_rep)) begin
            pushed = 0;
            if (lvl < (pr ? int'(DEPTH) - 1 : int'(DEPTH))) begin
                mq.push_back('{pr, sc});
                pushed = 1;
            end else begin
                m_ovf = 1;
            end
            if (pushed && pr && !lock) begin
                m_armed = 1; m_rep = sc; m_due = now + DLY;
            end else if (!pr && m_armed && sc == m_rep) begin
                m_armed = 0;
            end
        end
        if (m_armed && now >= m_due && !evt) begin
            if (ren && mq.size() < int'(DEPTH) - 1) mq.push_back('{1'b1, m_rep});
            m_due = now + RATE;
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [31:0] pk(input logic v, input logic mk, input logic [7:0] sc,
                                       input logic [3:0] lvl, input logic ov, input logic [2:0] ld);
        return {14'd0, ov, ld, lvl, v, mk, sc};
    endfunction

    function automatic logic [31:0] act();
        return pk(ev_valid, ev_make, ev_sc, {1'b0, ev_level}, ovf, led);
    endfunction

    function automatic logic [31:0] model_exp();
        if (mq.size() > 0) return pk(1'b1, mq[0].mk, mq[0].sc, 4'(mq.size()), m_ovf, m_led);
        return pk(1'b0, 1'b0, 8'h00, 4'd0, m_ovf, m_led);
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (ovf|led|level|valid|make|sc)", nm, a, e);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic p, input logic e, input logic [7:0] c);
        tog = ~tog; pr = p; ex = e; cd = c;
    endtask

    task automatic do_reset();
        rst = 1; tog = 0; pp = 0; clr = 0;
        tick();
        rst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst, en, tg, pr, ex; bit [7:0] cd; bit pp, clr;
        bit v, mk; bit [7:0] sc; bit [3:0] lvl; bit ov; bit [2:0] led;
    } vec_t;
    vec_t vt[$];

    task automatic add(input bit r, input bit e, input bit t, input bit p, input bit x, input bit [7:0] c,
                       input bit pop, input bit cl, input bit v, input bit mk, input bit [7:0] sc,
                       input bit [3:0] lvl, input bit ov, input bit [2:0] ld);
        vt.push_back('{r, e, t, p, x, c, pop, cl, v, mk, sc, lvl, ov, ld});
    endtask

    bit [7:0] codes [14] = '{8'h1C, 8'h1C, 8'h32, 8'h58, 8'h77, 8'h7E, 8'h75,
                             8'h12, 8'hF0, 8'h00, 8'h21, 8'h6B, 8'h1C, 8'hE1};

    initial begin
        rst = 1; en = 1; ren = 0; tog = 0; pr = 0; ex = 0; cd = 8'h00; pp = 0; clr = 0;

        //   rst en tg pr ex code  pop clr | v  mk sc    lvl ov led
        add(1, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h1C, 0, 0,   1, 1, 8'h1C, 1, 0, 3'b000);
        add(0, 1, 1, 0, 0, 8'h1C, 0, 0,   1, 1, 8'h1C, 2, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   1, 0, 8'h1C, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 1, 1, 8'h75, 0, 0,   1, 1, 8'h89, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 1, 1, 8'h12, 0, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'hF0, 0, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 0, 1, 8'h7A, 0, 0,   1, 0, 8'h8C, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h1C, 0, 0,   1, 1, 8'h1C, 1, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h32, 0, 0,   1, 1, 8'h1C, 2, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h21, 0, 0,   1, 1, 8'h1C, 3, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h23, 0, 0,   1, 1, 8'h1C, 3, 1, 3'b000);
        add(0, 1, 1, 0, 0, 8'h1C, 0, 0,   1, 1, 8'h1C, 4, 1, 3'b000);
        add(0, 1, 1, 0, 0, 8'h32, 0, 0,   1, 1, 8'h1C, 4, 1, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1,   1, 1, 8'h1C, 4, 0, 3'b000);
        add(0, 1, 1, 0, 0, 8'h32, 1, 0,   1, 1, 8'h32, 4, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h2B, 1, 0,   1, 1, 8'h21, 3, 1, 3'b000);
        add(0, 1, 1, 1, 0, 8'h2B, 0, 1,   1, 1, 8'h21, 3, 1, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1,   1, 1, 8'h21, 3, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   1, 0, 8'h1C, 2, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   1, 0, 8'h32, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 1, 1, 1, 0, 8'h1C, 0, 0,   1, 1, 8'h1C, 1, 0, 3'b000);
        add(1, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 3'b000);
        add(0, 0, 1, 1, 0, 8'h58, 0, 0,   0, 0, 8'h00, 0, 0, 3'b001);
        add(0, 0, 1, 1, 0, 8'h77, 0, 0,   0, 0, 8'h00, 0, 0, 3'b011);
        add(0, 1, 1, 1, 0, 8'h58, 0, 0,   1, 1, 8'h58, 1, 0, 3'b010);
        add(0, 1, 1, 1, 0, 8'h1C, 0, 0,   1, 1, 8'h58, 2, 0, 3'b010);
        add(0, 0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 3'b010);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 3'b010);
        add(1, 1, 0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 3'b000);

        foreach (vt[r]) begin
            rst = vt[r].rst; en = vt[r].en; pp = vt[r].pp; clr = vt[r].clr;
            if (vt[r].rst) tog = 0;
            if (vt[r].tg) key(vt[r].pr, vt[r].ex, vt[r].cd);
            tick();
            chk($sformatf("vec%0d", r), act(),
                pk(vt[r].v, vt[r].mk, vt[r].sc, vt[r].lvl, vt[r].ov, vt[r].led));
        end

        // Typematic: repeats at +20/+25/+30, host duplicate ignored, break stops repeating.
        en = 1; ren = 1;
        do_reset();
        key(1, 0, 8'h1C);
        tick();
        chk("t4_make", act(), pk(1, 1, 8'h1C, 1, 0, 3'b000));
        pp = 1;
        for (int e = 1; e <= 40; e++) begin
            logic [31:0] ex_v;
            if (e == 22) key(1, 0, 8'h1C);
            if (e == 32) key(0, 0, 8'h1C);
            tick();
            if (e == 20 || e == 25 || e == 30) ex_v = pk(1, 1, 8'h1C, 1, 0, 3'b000);
            else if (e == 32)                  ex_v = pk(1, 0, 8'h1C, 1, 0, 3'b000);
            else                               ex_v = pk(0, 0, 8'h00, 0, 0, 3'b000);
            chk($sformatf("t4_e%0d", e), act(), ex_v);
        end

        // Expiry coincident with a ps2 event: ps2 entry first, repeat one cycle later.
        do_reset();
        key(1, 0, 8'h1C);
        tick();
        chk("t5_make", act(), pk(1, 1, 8'h1C, 1, 0, 3'b000));
        pp = 1;
        for (int e = 1; e <= 30; e++) begin
            logic [31:0] ex_v;
            if (e == 20) key(0, 0, 8'h32);
            tick();
            if (e == 20)                 ex_v = pk(1, 0, 8'h32, 1, 0, 3'b000);
            else if (e == 21 || e == 26) ex_v = pk(1, 1, 8'h1C, 1, 0, 3'b000);
            else                         ex_v = pk(0, 0, 8'h00, 0, 0, 3'b000);
            chk($sformatf("t5_e%0d", e), act(), ex_v);
        end
        key(0, 0, 8'h1C);
        tick();
        pp = 0;

        // Randomized traffic against the reference model.
        do_reset();
        ren = 1;
        for (int i = 0; i < 4000; i++) begin
            int rate;
            rate = ((i / 500) % 2 == 0) ? 3 : 30;
            rst  = ($urandom_range(0, 399) == 0);
            en   = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 299) == 0) ren = ~ren;
            if ($urandom_range(0, rate - 1) == 0)
                key(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), codes[$urandom_range(0, 13)]);
            pp  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            tick();
            chk($sformatf("rand%0d", i), act(), model_exp());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
